// File: rtl/sram_access_arbiter.sv
// Two-requester (CPU / DMA) arbiter for a single asynchronous SRAM with fixed wait states.
// Define CPU_PRIORITY_EN for fixed CPU priority on ties; default build is round-robin.
//
// state    | meaning
// S_IDLE   | waiting for a request, arbitrates and latches the winner's access
// S_ACCESS | Mem_OE or Mem_WE held for WAIT_CYCLES cycles
// S_DONE   | owner's ack pulses, last_grant updated
module sram_access_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_we;
    logic       r_owner_dma;
    logic       r_last_dma;
    logic       w_grant_cpu;
    logic       w_grant_dma;
    logic       w_we_sel;

    always_comb begin
        w_grant_cpu = cpu_req;
        w_grant_dma = dma_req;
        if (cpu_req && dma_req) begin
`ifdef CPU_PRIORITY_EN
            w_grant_cpu = 1'b1;
            w_grant_dma = 1'b0;
`else
            w_grant_cpu = r_last_dma;
            w_grant_dma = ~r_last_dma;
`endif
        end
        w_we_sel = w_grant_dma ? dma_we : cpu_we;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_owner_dma <= 1'b0;
            r_last_dma  <= 1'b1;
            cpu_ack     <= 1'b0;
            dma_ack     <= 1'b0;
            cpu_rdata   <= '0;
            dma_rdata   <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            Mem_OE      <= 1'b0;
            Mem_WE      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_cpu || w_grant_dma) begin
                        r_owner_dma <= w_grant_dma;
                        r_we        <= w_we_sel;
                        mem_addr    <= w_grant_dma ? dma_addr : cpu_addr;
                        mem_wdata   <= w_grant_dma ? dma_wdata : cpu_wdata;
                        r_cnt       <= WAIT_LOAD;
                        Mem_OE      <= ~w_we_sel;
                        Mem_WE      <= w_we_sel;
                        busy        <= 1'b1;
                        r_state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        Mem_OE <= 1'b0;
                        Mem_WE <= 1'b0;
                        // read data sampled on the last strobe cycle
                        if (!r_we) begin
                            if (r_owner_dma) dma_rdata <= mem_rdata;
                            else             cpu_rdata <= mem_rdata;
                        end
                        cpu_ack <= ~r_owner_dma;
                        dma_ack <= r_owner_dma;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_last_dma <= r_owner_dma;
                    busy       <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
